// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for a dual-clock FIFO storage array.
//
// Runs entirely in the read clock domain. Keeps the binary/Gray read pointer,
// compares it with the write pointer that has already been synchronised into
// this domain, and produces registered empty/level/almost-empty status. It
// drives the array's combinational read port and presents data through a
// registered first-word-fall-through output stage with a valid/ready handshake.
//
// Ports:
//   rd_clk           read-domain clock, rising edge
//   rd_rst           synchronous active-high reset
//   rd_wptr_sync     Gray write pointer, already synchronised to rd_clk
//   rd_data_mem      array read data, combinational from rd_addr
//   rd_ena           array read enable, high only in a fetch cycle
//   rd_addr          array read address (low bits of the binary read pointer)
//   rd_gptr          registered Gray read pointer for the write-domain synchroniser
//   rd_empty         registered: no unfetched words in the array
//   rd_almost_empty  registered: rd_level <= ALMOST_EMPTY
//   rd_level         registered count of unfetched words (output register excluded)
//   dout             output data
//   dout_valid       dout holds a word
//   dout_ready       consumer accepts dout when dout_valid & dout_ready

module fifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDR_SIZE:0]    rd_wptr_sync,
    input  logic [DATA_WIDTH-1:0] rd_data_mem,
    output logic                  rd_ena,
    output logic [ADDR_SIZE-1:0]  rd_addr,
    output logic [ADDR_SIZE:0]    rd_gptr,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_SIZE:0]    rd_level,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int unsigned PtrW = ADDR_SIZE + 1;
    localparam logic [PtrW-1:0] AeLevel = PtrW'(ALMOST_EMPTY);

    logic [PtrW-1:0]       rbin_q, rbin_d;
    logic [PtrW-1:0]       rgray_q, rgray_d;
    logic                  empty_q, empty_d;
    logic                  aempty_q, aempty_d;
    logic [PtrW-1:0]       level_q, level_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic [PtrW-1:0]       wbin_s;
    logic                  fetch;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < int'(PtrW); i++) begin
            wbin_s[i] = ^(rd_wptr_sync >> i);
        end
    end

    // Gating with rd_rst keeps the array port quiet for the whole reset cycle.
    assign fetch = !rd_rst && !empty_q && (!valid_q || dout_ready);

    always_comb begin
        rbin_d   = rbin_q + PtrW'(fetch);
        rgray_d  = rbin_d ^ (rbin_d >> 1);
        // Status is computed from the next pointer so it reflects this cycle's fetch.
        level_d  = wbin_s - rbin_d;
        empty_d  = (rbin_d == wbin_s);
        aempty_d = (level_d <= AeLevel);

        dout_d  = dout_q;
        valid_d = valid_q;
        if (fetch) begin
            dout_d  = rd_data_mem;
            valid_d = 1'b1;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_ena          = fetch;
    assign rd_addr         = rbin_q[ADDR_SIZE-1:0];
    assign rd_gptr         = rgray_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = aempty_q;
    assign rd_level        = level_q;
    assign dout            = dout_q;
    assign dout_valid      = valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed vectors with a scoreboard of expected words
// and a negedge monitor that checks data order, read addresses and the Gray pointer.

module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] wptr_sync;
    logic [7:0] mem_rdata;
    logic       rd_ena;
    logic [3:0] rd_addr;
    logic [4:0] rd_gptr;
    logic       rd_empty;
    logic       rd_almost_empty;
    logic [4:0] rd_level;
    logic [7:0] dout;
    logic       dout_valid;
    logic       ready;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int wraps = 0;
    logic [4:0] exp_rbin = '0;
    logic [4:0] prev_g = '0;
    logic       skip_g = 1'b1;

    fifo_rd_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_SIZE   (4),
        .ALMOST_EMPTY(2)
    ) dut (
        .rd_clk         (clk),
        .rd_rst         (rst),
        .rd_wptr_sync   (wptr_sync),
        .rd_data_mem    (mem_rdata),
        .rd_ena         (rd_ena),
        .rd_addr        (rd_addr),
        .rd_gptr        (rd_gptr),
        .rd_empty       (rd_empty),
        .rd_almost_empty(rd_almost_empty),
        .rd_level       (rd_level),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = 8'h00;
        if (rd_ena) mem_rdata = mem[rd_addr];
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rst) begin
            check("ena_in_reset", {31'd0, rd_ena}, 32'd0);
            exp_rbin = '0;
            sb.delete();
            skip_g = 1'b1;
        end else begin
            check("gptr_model", {27'd0, rd_gptr}, {27'd0, gray(exp_rbin)});
            if (!skip_g && rd_gptr !== prev_g)
                check("gptr_onebit", $countones(rd_gptr ^ prev_g), 32'd1);
            skip_g = 1'b0;
            if (rd_ena) begin
                check("rd_addr", {28'd0, rd_addr}, {28'd0, exp_rbin[3:0]});
                if (exp_rbin[3:0] == 4'd15) wraps++;
                exp_rbin = exp_rbin + 5'd1;
            end
            if (dout_valid && ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dout_unexpected: got 0x%0h, no word expected (t=%0t)",
                             dout, $time);
                end else begin
                    check("dout", {24'd0, dout}, {24'd0, sb.pop_front()});
                end
            end
        end
        prev_g = rd_gptr;
    end

    task automatic do_reset();
        rst = 1'b1;
        wbin = '0;
        wptr_sync = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] v);
        mem[wbin[3:0]] = v;
        sb.push_back(v);
        wbin = wbin + 5'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int cyc;
        bit done;
        logic [7:0] v;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ready = 1'b0;

        // Reset values
        do_reset();
        check("rst_empty", {31'd0, rd_empty}, 32'd1);
        check("rst_aempty", {31'd0, rd_almost_empty}, 32'd1);
        check("rst_level", {27'd0, rd_level}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_gptr", {27'd0, rd_gptr}, 32'd0);
        check("rst_ena", {31'd0, rd_ena}, 32'd0);

        // Single word
        write_word(8'hA5);
        wptr_sync = gray(wbin);
        ready = 1'b1;
        tick();
        check("sw_empty_fall", {31'd0, rd_empty}, 32'd0);
        check("sw_ena", {31'd0, rd_ena}, 32'd1);
        check("sw_addr", {28'd0, rd_addr}, 32'd0);
        check("sw_level1", {27'd0, rd_level}, 32'd1);
        tick();
        check("sw_valid", {31'd0, dout_valid}, 32'd1);
        check("sw_dout", {24'd0, dout}, 32'hA5);
        check("sw_gptr", {27'd0, rd_gptr}, 32'd1);
        check("sw_empty", {31'd0, rd_empty}, 32'd1);
        check("sw_level0", {27'd0, rd_level}, 32'd0);
        check("sw_ena_off", {31'd0, rd_ena}, 32'd0);
        tick();
        tick();
        check("sw_valid_drop", {31'd0, dout_valid}, 32'd0);

        // Backpressure
        ready = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        wptr_sync = gray(wbin);
        for (int i = 0; i < 4; i++) tick();
        check("bp_dout", {24'd0, dout}, 32'h11);
        check("bp_valid", {31'd0, dout_valid}, 32'd1);
        check("bp_level", {27'd0, rd_level}, 32'd2);
        check("bp_aempty", {31'd0, rd_almost_empty}, 32'd1);
        check("bp_ena", {31'd0, rd_ena}, 32'd0);
        ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_valid_drop", {31'd0, dout_valid}, 32'd0);
        check("bp_empty", {31'd0, rd_empty}, 32'd1);

        // Full drain from reset
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i * 3));
        wptr_sync = gray(wbin);
        check("fd_wptr_gray16", {27'd0, wptr_sync}, 32'h18);
        ready = 1'b1;
        tick();
        check("fd_level16", {27'd0, rd_level}, 32'd16);
        check("fd_aempty16", {31'd0, rd_almost_empty}, 32'd0);
        check("fd_valid0", {31'd0, dout_valid}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("fd_level", {27'd0, rd_level}, 32'(16 - k));
            check("fd_aempty", {31'd0, rd_almost_empty}, {31'd0, (16 - k) <= 2});
            check("fd_valid", {31'd0, dout_valid}, 32'd1);
            check("fd_ena", {31'd0, rd_ena}, {31'd0, k < 16});
        end
        tick();
        check("fd_valid_end", {31'd0, dout_valid}, 32'd0);

        // Wrap: 40 words in chunks of 8 with random backpressure
        w0 = wraps;
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < 8; j++) begin
                v = 8'(c * 37 + j * 11 + 3);
                write_word(v);
            end
            wptr_sync = gray(wbin);
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 200) begin
                tick();
                cyc++;
                ready = ($urandom_range(0, 3) != 0);
                if (cyc >= 2 && rd_empty && !dout_valid) done = 1'b1;
            end
            check("wrap_drain_done", {31'd0, done}, 32'd1);
        end
        ready = 1'b1;
        tick();
        check("wrap_count", 32'(wraps - w0), 32'd2);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        check("wrap_gptr_final", {27'd0, rd_gptr}, {27'd0, gray(5'd24)});

        // Reset mid-burst
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'hC0 + 8'(i));
        wptr_sync = gray(wbin);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ready = 1'b0;
        check("mr_valid", {31'd0, dout_valid}, 32'd1);
        check("mr_level5", {27'd0, rd_level}, 32'd5);
        check("mr_dout", {24'd0, dout}, 32'hC2);
        rst = 1'b1;
        wbin = '0;
        wptr_sync = '0;
        tick();
        check("mr_empty", {31'd0, rd_empty}, 32'd1);
        check("mr_aempty", {31'd0, rd_almost_empty}, 32'd1);
        check("mr_level", {27'd0, rd_level}, 32'd0);
        check("mr_valid0", {31'd0, dout_valid}, 32'd0);
        check("mr_dout0", {24'd0, dout}, 32'd0);
        check("mr_gptr", {27'd0, rd_gptr}, 32'd0);
        check("mr_ena", {31'd0, rd_ena}, 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        tick();
        check("mr_post_empty", {31'd0, rd_empty}, 32'd1);
        check("mr_post_valid", {31'd0, dout_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
